// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment reader: pattern constants (also used
// by the BCD-to-segment encoder), FSM state encoding and port widths.
package seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ERRCNT_W = 8;
  localparam int unsigned RUN_W    = 4;
  localparam int unsigned STATE_W  = 2;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [SEG_W-1:0] SEG_PAT_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_PAT_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_PAT_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_PAT_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_PAT_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_PAT_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_PAT_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_PAT_7 = 7'b1011000;
  localparam logic [SEG_W-1:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_PAT_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_PAT_A = 7'b1111111;  // blank
  localparam logic [SEG_W-1:0] SEG_PAT_B = 7'b0111111;  // dash
  localparam logic [SEG_W-1:0] SEG_PAT_C = 7'b0001001;  // H
  localparam logic [SEG_W-1:0] SEG_PAT_D = 7'b1000111;  // L
  localparam logic [SEG_W-1:0] SEG_PAT_E = 7'b0000110;  // E
  localparam logic [SEG_W-1:0] SEG_PAT_F = 7'b0001100;  // P

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_TRACK = 2'd1;
  localparam logic [STATE_W-1:0] S_HOLD  = 2'd2;

endpackage

// File: rtl/seg_lookup.sv
// Combinational segment-pattern to code decoder; hit=0 for unrecognised patterns.
module seg_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]  pat,
  output logic [CODE_W-1:0] code,
  output logic              hit
);

  // Table decode with a miss default
  always_comb begin
    code = '0;
    hit  = 1'b1;
    case (pat)
      SEG_PAT_0: code = 4'h0;
      SEG_PAT_1: code = 4'h1;
      SEG_PAT_2: code = 4'h2;
      SEG_PAT_3: code = 4'h3;
      SEG_PAT_4: code = 4'h4;
      SEG_PAT_5: code = 4'h5;
      SEG_PAT_6: code = 4'h6;
      SEG_PAT_7: code = 4'h7;
      SEG_PAT_8: code = 4'h8;
      SEG_PAT_9: code = 4'h9;
      SEG_PAT_A: code = 4'hA;
      SEG_PAT_B: code = 4'hB;
      SEG_PAT_C: code = 4'hC;
      SEG_PAT_D: code = 4'hD;
      SEG_PAT_E: code = 4'hE;
      SEG_PAT_F: code = 4'hF;
      default:   hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Seven-segment pattern reader: debounces strobed patterns and decodes them
// into a 4-bit code, flagging unrecognised patterns.
// Define SEG_STABLE_FILTER_EN to require STABLE_CNT identical strobes before
// a pattern is accepted; otherwise every change of pattern is accepted at once.
module seg_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEG_W-1:0]    seg_in,
  input  logic                seg_vld,
  output logic [CODE_W-1:0]   code,
  output logic                code_vld,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                busy
);

  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(STABLE_CNT);

  logic [STATE_W-1:0]  state_q, state_nx;
  logic [SEG_W-1:0]    cand_q, cand_nx;
  logic [RUN_W-1:0]    run_q, run_nx;
  logic [RUN_W-1:0]    run_inc;
  logic [CODE_W-1:0]   code_nx;
  logic                code_vld_nx, err_nx, busy_nx;
  logic [ERRCNT_W-1:0] err_cnt_nx;
  logic                accept_c;
  logic [CODE_W-1:0]   lk_code;
  logic                lk_hit;

  seg_lookup u_lookup (
    .pat  (seg_in),
    .code (lk_code),
    .hit  (lk_hit)
  );

  assign run_inc = run_q + RUN_W'(1);

`ifndef SEG_STABLE_FILTER_EN
  logic [RUN_W-1:0] unused_run_tgt;
  logic [RUN_W-1:0] unused_run_inc;
  assign unused_run_tgt = RUN_TGT;
  assign unused_run_inc = run_inc;
`endif

  // Next-state, candidate tracking and output computation
  always_comb begin
    state_nx    = state_q;
    cand_nx     = cand_q;
    run_nx      = run_q;
    accept_c    = 1'b0;
    code_nx     = code;
    code_vld_nx = 1'b0;
    err_nx      = 1'b0;
    err_cnt_nx  = err_cnt;

`ifdef SEG_STABLE_FILTER_EN
    case (state_q)
      S_IDLE: begin
        if (seg_vld) begin
          cand_nx  = seg_in;
          run_nx   = RUN_W'(1);
          state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (seg_vld) begin
          if (seg_in == cand_q) begin
            run_nx = run_inc;
            if (run_inc == RUN_TGT) begin
              accept_c = 1'b1;
              state_nx = S_HOLD;
            end
          end else begin
            cand_nx = seg_in;
            run_nx  = RUN_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (seg_vld && (seg_in != cand_q)) begin
          cand_nx  = seg_in;
          run_nx   = RUN_W'(1);
          state_nx = S_TRACK;
        end
      end
      default: state_nx = S_IDLE;
    endcase
`else
    // cand_q holds the last accepted pattern once in HOLD
    case (state_q)
      S_IDLE: begin
        if (seg_vld) begin
          accept_c = 1'b1;
          cand_nx  = seg_in;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (seg_vld && (seg_in != cand_q)) begin
          accept_c = 1'b1;
          cand_nx  = seg_in;
        end
      end
      default: state_nx = S_IDLE;
    endcase
`endif

    if (accept_c) begin
      if (lk_hit) begin
        code_nx     = lk_code;
        code_vld_nx = 1'b1;
      end else begin
        err_nx = 1'b1;
        if (err_cnt != {ERRCNT_W{1'b1}}) begin
          err_cnt_nx = err_cnt + ERRCNT_W'(1);
        end
      end
    end

    busy_nx = (state_nx == S_TRACK);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      run_q    <= '0;
      code     <= '0;
      code_vld <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cand_q   <= cand_nx;
      run_q    <= run_nx;
      code     <= code_nx;
      code_vld <= code_vld_nx;
      err      <= err_nx;
      err_cnt  <= err_cnt_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader; the reference model follows the build's
// SEG_STABLE_FILTER_EN setting.
module tb_seg_reader;

  localparam int SC = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       seg_vld;
  logic [3:0] code;
  logic       code_vld;
  logic       err;
  logic [7:0] err_cnt;
  logic       busy;

  seg_reader #(.STABLE_CNT(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .seg_vld  (seg_vld),
    .code     (code),
    .code_vld (code_vld),
    .err      (err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table, index = code
  logic [6:0] tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
    7'b0001001, 7'b1000111, 7'b0000110, 7'b0001100
  };

  typedef struct packed {
    logic       is_err;
    logic [3:0] code;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;

  logic       started = 1'b0;
  logic [3:0] m_code;
  int         m_err_cnt;
  logic       m_busy;
  logic       m_have;
  logic [6:0] m_pat;
  int         m_run;

  function automatic int find_code(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  function automatic void do_accept(input logic [6:0] p);
    int c;
    exp_t e;
    c = find_code(p);
    if (c >= 0) begin
      m_code   = 4'(c);
      e.is_err = 1'b0;
      e.code   = 4'(c);
    end else begin
      if (m_err_cnt < 255) m_err_cnt++;
      e.is_err = 1'b1;
      e.code   = 4'h0;
    end
    q.push_back(e);
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: reacts to the stimulus seen at each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_code    = 4'h0;
      m_err_cnt = 0;
      m_busy    = 1'b0;
      m_have    = 1'b0;
      m_pat     = 7'h0;
      m_run     = 0;
      started   = 1'b1;
    end else if (seg_vld) begin
`ifdef SEG_STABLE_FILTER_EN
      if (m_have && seg_in == m_pat) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_pat  = seg_in;
        m_run  = 1;
        m_have = 1'b1;
      end
      if (m_run == SC) do_accept(seg_in);
      m_busy = (m_run < SC);
`else
      if (!m_have || seg_in != m_pat) begin
        do_accept(seg_in);
        m_pat  = seg_in;
        m_have = 1'b1;
      end
      m_busy = 1'b0;
`endif
    end
  end

  // Monitor: pops expected pulses and compares held outputs mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("pulse_exclusive", int'(code_vld & err), 0);
      if (code_vld || err) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got code_vld=%0b err=%0b code=%0d expected no pulse at %0t",
                   code_vld, err, code, $time);
        end else begin
          e = q.pop_front();
          chk("pulse_err", int'(err), int'(e.is_err));
          chk("pulse_code_vld", int'(code_vld), int'(!e.is_err));
          if (!e.is_err) chk("pulse_code", int'(code), int'(e.code));
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_pulse: got no pulse expected err=%0b code=%0d at %0t",
                 e.is_err, e.code, $time);
      end
      chk("code_held", int'(code), int'(m_code));
      chk("err_cnt", int'(err_cnt), m_err_cnt);
      chk("busy", int'(busy), int'(m_busy));
    end
  end

  task automatic strobe(input logic [6:0] p);
    seg_in  = p;
    seg_vld = 1'b1;
    @(posedge clk);
    #1;
    seg_vld = 1'b0;
  endtask

  task automatic gap(input int n);
    seg_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    seg_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] pool [5];
    logic [6:0] p;
    int         n;

    rst_n   = 1'b0;
    seg_vld = 1'b0;
    seg_in  = 7'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values right after release
    @(negedge clk);
    chk("reset_code", int'(code), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;

`ifdef SEG_STABLE_FILTER_EN
    // Stable acceptance and no re-emission
    repeat (5) strobe(7'b0110000);
    gap(2);
    // Bouncing between 5 and 6 settles on 6
    strobe(7'b0010010);
    strobe(7'b0010010);
    repeat (5) strobe(7'b0000010);
    gap(2);
    // Unrecognised stable pattern
    repeat (SC) strobe(7'b1010101);
    gap(2);
    // Saturation with alternating bad patterns
    for (int i = 0; i < 300; i++) begin
      repeat (SC) strobe((i % 2 == 0) ? 7'b0101010 : 7'b1010101);
    end
    gap(2);
    chk("err_cnt_saturated", int'(err_cnt), 255);
    // Reset mid-track discards the candidate; first strobe after release counts
    for (int i = 0; i < 3; i++) begin
      strobe(7'b1000000);
      gap(2);
    end
    do_reset();
    strobe(7'b1000000);
    @(negedge clk);
    chk("busy_after_reset_strobe", int'(busy), 1);
    chk("no_pulse_after_reset", int'(code_vld), 0);
    @(posedge clk);
    #1;
`else
    // Immediate acceptance on every change
    strobe(7'b1111001);
    strobe(7'b1111001);
    strobe(7'b0001100);
    gap(2);
    chk("code_after_seq", int'(code), 15);
    // Saturation with alternating bad patterns
    for (int i = 0; i < 300; i++) begin
      strobe((i % 2 == 0) ? 7'b0101010 : 7'b1010101);
    end
    gap(2);
    chk("err_cnt_saturated", int'(err_cnt), 255);
    // First strobe after reset always accepts
    strobe(7'b1000000);
    do_reset();
    strobe(7'b1000000);
    gap(1);
`endif

    // Randomized runs of repeated patterns with gaps and occasional reset
    for (int i = 0; i < 4; i++) pool[i] = tbl[$urandom_range(0, 15)];
    pool[4] = 7'b1100110;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 8) p = pool[$urandom_range(0, 4)];
      else p = 7'($urandom);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        strobe(p);
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    gap(4);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
